// File: rtl/ddr_dispatch_pkg.sv
// Shared constants for the DDR dispatch arbiter: app command codes
// and the dispatcher state encoding.
package ddr_dispatch_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/wr_beat_serializer.sv
// Holds one captured wide write word and emits it LSB-first as BEATS
// app-width beats (app_wdf_data/wren/end), stalling on app_wdf_rdy.
// Ports: load/word_in capture a new word; app_wdf_* is the beat stream.
module wr_beat_serializer
  import ddr_dispatch_pkg::*;
#(
  parameter int APP_DATA_W = 64,
  parameter int BEATS      = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load,
  input  logic [APP_DATA_W*BEATS-1:0]   word_in,
  input  logic                          app_wdf_rdy,
  output logic [APP_DATA_W-1:0]         app_wdf_data,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  logic [APP_DATA_W*BEATS-1:0] word;
  logic [BW-1:0]               beat;
  logic [BW-1:0]               beat_n;

  assign beat_n = beat + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      word         <= '0;
      beat         <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
    end else if (load) begin
      word         <= word_in;
      beat         <= '0;
      app_wdf_data <= word_in[APP_DATA_W-1:0];
      app_wdf_wren <= 1'b1;
      app_wdf_end  <= (LAST == '0);
    end else if (app_wdf_wren && app_wdf_rdy) begin
      if (app_wdf_end) begin
        app_wdf_wren <= 1'b0;
        app_wdf_end  <= 1'b0;
      end else begin
        beat         <= beat_n;
        app_wdf_data <= word[int'(beat_n)*APP_DATA_W +: APP_DATA_W];
        app_wdf_end  <= (beat_n == LAST);
      end
    end
  end

endmodule

// File: rtl/ddr_dispatch_arb.sv
// Read/write dispatcher to the DDR app interface with a bounded-run
// arbiter. Ports: FIFO heads/pops (has_*, *_in, get_*), app command
// (app_addr/cmd/en/rdy), write beats (app_wdf_*), busy, last_was_wr.
module ddr_dispatch_arb #(
  parameter int ADDR_W     = 27,
  parameter int APP_DATA_W = 64,
  parameter int BEATS      = 2,
  parameter int MAX_RUN    = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        has_wr_data,
  input  logic                        has_wr_adx,
  input  logic [APP_DATA_W*BEATS-1:0] wr_data_in,
  input  logic [ADDR_W-1:0]           wr_adx_in,
  output logic                        get_wr_data,
  output logic                        get_wr_adx,
  input  logic                        has_rd_req,
  input  logic [ADDR_W-1:0]           rd_adx_in,
  output logic                        get_rd_req,
  output logic [ADDR_W-1:0]           app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  input  logic                        app_rdy,
  output logic [APP_DATA_W-1:0]       app_wdf_data,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  input  logic                        app_wdf_rdy,
  output logic                        busy,
  output logic                        last_was_wr
);

  import ddr_dispatch_pkg::*;

  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

  state_t           state, state_n;
  logic [RUN_W-1:0] run;
  logic             wr_ok, rd_ok, keep;
  logic             pick_wr, pick_rd;
  logic             cmd_fin, wr_fin, load;

  always_comb begin
    wr_ok   = has_wr_data & has_wr_adx;
    rd_ok   = has_rd_req;
    // run==0 only after reset: treat a tie as a switch, i.e. to write
    keep    = (run != '0) && (run < RUN_MAX);
    pick_wr = 1'b0;
    pick_rd = 1'b0;
    if (wr_ok && rd_ok) begin
      if (keep ? last_was_wr : !last_was_wr) pick_wr = 1'b1;
      else                                   pick_rd = 1'b1;
    end else begin
      pick_wr = wr_ok;
      pick_rd = rd_ok;
    end
    // each side is done once its strobe has dropped or is accepted now
    cmd_fin = !app_en | app_rdy;
    wr_fin  = !app_wdf_wren | (app_wdf_rdy & app_wdf_end);
    state_n = state;
    unique case (state)
      IDLE: begin
        if (pick_wr)      state_n = WR;
        else if (pick_rd) state_n = RD;
      end
      WR:      if (cmd_fin && wr_fin) state_n = IDLE;
      RD:      if (cmd_fin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign load = (state == IDLE) && pick_wr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      run         <= '0;
      busy        <= 1'b0;
      last_was_wr <= 1'b0;
      get_wr_data <= 1'b0;
      get_wr_adx  <= 1'b0;
      get_rd_req  <= 1'b0;
      app_en      <= 1'b0;
      app_addr    <= '0;
      app_cmd     <= '0;
    end else begin
      state       <= state_n;
      busy        <= (state_n != IDLE);
      get_wr_data <= 1'b0;
      get_wr_adx  <= 1'b0;
      get_rd_req  <= 1'b0;
      if (state == IDLE && (pick_wr || pick_rd)) begin
        app_en      <= 1'b1;
        last_was_wr <= pick_wr;
        if (last_was_wr != pick_wr) run <= RUN_W'(1);
        else if (run != RUN_MAX)    run <= run + 1'b1;
        if (pick_wr) begin
          get_wr_data <= 1'b1;
          get_wr_adx  <= 1'b1;
          app_addr    <= wr_adx_in;
          app_cmd     <= CMD_WRITE;
        end else begin
          get_rd_req  <= 1'b1;
          app_addr    <= rd_adx_in;
          app_cmd     <= CMD_READ;
        end
      end else if (app_en && app_rdy) begin
        app_en <= 1'b0;
      end
    end
  end

  wr_beat_serializer #(
    .APP_DATA_W (APP_DATA_W),
    .BEATS      (BEATS)
  ) u_ser (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .word_in      (wr_data_in),
    .app_wdf_rdy  (app_wdf_rdy),
    .app_wdf_data (app_wdf_data),
    .app_wdf_wren (app_wdf_wren),
    .app_wdf_end  (app_wdf_end)
  );

endmodule

// File: tb/tb_ddr_dispatch_arb.sv
// Scoreboard bench for ddr_dispatch_arb: FIFO model drives requests,
// a negedge monitor pops expected commands/beats and compares.
module tb_ddr_dispatch_arb;

  localparam int AW = 27;
  localparam int DW = 64;
  localparam int NB = 2;
  localparam int MR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn;
  logic           has_wr_data = 1'b0, has_wr_adx = 1'b0, has_rd_req = 1'b0;
  logic [DW*NB-1:0] wr_data_in = '0;
  logic [AW-1:0]  wr_adx_in = '0, rd_adx_in = '0;
  logic           get_wr_data, get_wr_adx, get_rd_req;
  logic [AW-1:0]  app_addr;
  logic [2:0]     app_cmd;
  logic           app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0]  app_wdf_data;
  logic           busy, last_was_wr;

  ddr_dispatch_arb #(.ADDR_W(AW), .APP_DATA_W(DW), .BEATS(NB), .MAX_RUN(MR)) dut (
    .clk(clk), .resetn(resetn),
    .has_wr_data(has_wr_data), .has_wr_adx(has_wr_adx),
    .wr_data_in(wr_data_in), .wr_adx_in(wr_adx_in),
    .get_wr_data(get_wr_data), .get_wr_adx(get_wr_adx),
    .has_rd_req(has_rd_req), .rd_adx_in(rd_adx_in), .get_rd_req(get_rd_req),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .busy(busy), .last_was_wr(last_was_wr)
  );

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    int            en_len;
    int            gap;
  } exp_cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            hold;
  } exp_beat_t;

  exp_cmd_t  ecq[$];
  exp_beat_t ebq[$];
  logic [DW*NB-1:0] wdq[$];
  logic [AW-1:0]    waq[$];
  logic [AW-1:0]    rq[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_pops = 0;
  logic block_adx = 1'b0;
  logic wren_seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: pops take effect just after the edge that consumed them
  initial begin
    logic gwd, gwa, grd;
    forever begin
      @(negedge clk);
      gwd = get_wr_data;
      gwa = get_wr_adx;
      grd = get_rd_req;
      if (gwd || gwa) chk("pop_pair", gwa, gwd);
      if (gwd) chk("wr_pop_nonempty", wdq.size() != 0, 1);
      if (grd) chk("rd_pop_nonempty", rq.size() != 0, 1);
      @(posedge clk);
      #1;
      if (gwd && wdq.size() != 0) void'(wdq.pop_front());
      if (gwa && waq.size() != 0) void'(waq.pop_front());
      if (grd && rq.size() != 0) void'(rq.pop_front());
      if (gwd) wr_pops++;
      has_wr_data = (wdq.size() != 0);
      has_wr_adx  = (waq.size() != 0) && !block_adx;
      has_rd_req  = (rq.size() != 0);
      wr_data_in  = (wdq.size() != 0) ? wdq[0] : '0;
      wr_adx_in   = (waq.size() != 0) ? waq[0] : '0;
      rd_adx_in   = (rq.size() != 0) ? rq[0] : '0;
    end
  end

  // monitor
  exp_cmd_t  mc;
  exp_beat_t mb;
  int en_cnt = 0, hold = 0, last_acc = -1;

  always @(negedge clk) begin
    if (!resetn) begin
      en_cnt = 0;
      hold = 0;
      last_acc = -1;
      chk("get_in_reset", {get_wr_data, get_wr_adx, get_rd_req}, 0);
    end else begin
      if (app_wdf_wren) wren_seen = 1'b1;
      if (app_en) begin
        en_cnt++;
        if (app_rdy) begin
          if (ecq.size() == 0) begin
            chk("unexpected_cmd", {app_cmd, app_addr}, 0);
          end else begin
            mc = ecq.pop_front();
            chk("cmd", app_cmd, mc.cmd);
            chk("addr", app_addr, mc.addr);
            chk("last_was_wr", last_was_wr, mc.cmd == 3'b000);
            if (mc.en_len >= 0) chk("en_len", en_cnt, mc.en_len);
            if (mc.gap >= 0 && last_acc >= 0) chk("cmd_gap", cyc - last_acc, mc.gap);
          end
          last_acc = cyc;
          en_cnt = 0;
        end
      end
      if (app_wdf_wren) begin
        hold++;
        if (ebq.size() == 0) begin
          chk("unexpected_beat", app_wdf_data, 0);
        end else begin
          chk("beat_data", app_wdf_data, ebq[0].data);
          if (app_wdf_rdy) begin
            mb = ebq.pop_front();
            chk("beat_end", app_wdf_end, mb.last);
            if (mb.hold >= 0) chk("beat_hold", hold, mb.hold);
            hold = 0;
          end
        end
      end
    end
  end

  task automatic push_wr(logic [DW*NB-1:0] d, logic [AW-1:0] a);
    wdq.push_back(d);
    waq.push_back(a);
  endtask

  task automatic exp_wr(logic [DW*NB-1:0] d, logic [AW-1:0] a,
                        int en_len, int h0, int h1);
    ecq.push_back('{3'b000, a, en_len, -1});
    ebq.push_back('{d[DW-1:0], 1'b0, h0});
    ebq.push_back('{d[2*DW-1:DW], 1'b1, h1});
  endtask

  task automatic exp_rd(logic [AW-1:0] a, int gap);
    ecq.push_back('{3'b001, a, 1, gap});
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((ecq.size() != 0 || ebq.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, ecq.size() + ebq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_en(int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!app_en && n < budget);
    chk("wait_app_en", app_en, 1);
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_ctrl"}, {app_en, app_wdf_wren, app_wdf_end, get_wr_data,
                         get_wr_adx, get_rd_req, busy, last_was_wr}, 0);
    chk({tag, "_addr"}, app_addr, 0);
    chk({tag, "_cmd"}, app_cmd, 0);
    chk({tag, "_data"}, app_wdf_data, 0);
  endtask

  initial begin
    int p0;
    string ord;
    int wi, ri;
    logic [DW*NB-1:0] d;

    resetn = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    resetn = 1'b1;

    // single write
    d = 128'hAAAAAAAAAAAAAAAA_5555555555555555;
    push_wr(d, 27'h100);
    exp_wr(d, 27'h100, 1, 1, 1);
    drain("t1_drain", 50);
    chk("t1_pops", wr_pops, 1);

    // backpressure on command and on beat 1
    app_rdy = 1'b0;
    d = 128'h0123456789ABCDEF_FEDCBA9876543210;
    push_wr(d, 27'h2A5);
    exp_wr(d, 27'h2A5, 4, 1, 3);
    wait_en(20);
    @(posedge clk);
    #1;
    app_wdf_rdy = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    drain("t2_drain", 50);
    chk("t2_pops", wr_pops, 2);

    // fairness from reset with MAX_RUN=4
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_wr({64'hC0DE000000000000 | 64'(i), 64'h00000000BEEF0000 | 64'(i)},
              27'h200 + 27'(i));
      rq.push_back(27'h300 + 27'(i));
    end
    ord = "WWWWRRRRWWWWRRRRWWRR";
    wi = 0;
    ri = 0;
    for (int i = 0; i < 20; i++) begin
      if (ord[i] == "W") begin
        exp_wr({64'hC0DE000000000000 | 64'(wi), 64'h00000000BEEF0000 | 64'(wi)},
               27'h200 + 27'(wi), 1, 1, 1);
        wi++;
      end else begin
        exp_rd(27'h300 + 27'(ri), -1);
        ri++;
      end
    end
    drain("t3_drain", 400);

    // reads only: 2 cycles each, no write beats
    wren_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rq.push_back(27'h400 + 27'(i));
      exp_rd(27'h400 + 27'(i), (i == 0) ? -1 : 2);
    end
    drain("t4_drain", 100);
    chk("t4_no_wren", wren_seen, 0);

    // write data present but no address: reads still served
    block_adx = 1'b1;
    p0 = wr_pops;
    d = 128'h1111111111111111_2222222222222222;
    push_wr(d, 27'h500);
    rq.push_back(27'h600);
    rq.push_back(27'h601);
    exp_rd(27'h600, -1);
    exp_rd(27'h601, 2);
    exp_wr(d, 27'h500, 1, 1, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_wr_pop", wr_pops, p0);
    chk("t5_reads_done", ecq.size(), 1);
    block_adx = 1'b0;
    drain("t5_drain", 50);
    chk("t5_wr_pop", wr_pops, p0 + 1);

    // reset in the middle of a write
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    d = 128'h3333333333333333_4444444444444444;
    push_wr(d, 27'h7FF);
    exp_wr(d, 27'h7FF, -1, -1, -1);
    wait_en(20);
    @(posedge clk);
    #1;
    chk("t6_busy_before", busy, 1);
    resetn = 1'b0;
    ecq.delete();
    ebq.delete();
    @(posedge clk);
    #1;
    check_idle("midrst");
    resetn = 1'b1;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    p0 = wr_pops;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_refetch", {busy, app_en, app_wdf_wren}, 0);
    chk("t6_no_pop", wr_pops, p0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
